// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default frame parameters and a
// helper that turns a clock frequency and a baud rate into cycles per bit.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DEFAULT_BPS_MAX = 5208;
  localparam int DEFAULT_BIT_MAX = 8;

  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous input; the reset
// value lets idle-high lines come out of reset without a spurious edge.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit validation at half a bit, data sampled at bit
// centres, stop bit checked before the byte is published with a valid pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BPS_MAX = DEFAULT_BPS_MAX,
  parameter int BIT_MAX = DEFAULT_BIT_MAX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  output logic [BIT_MAX-1:0] rx_data,
  output logic               rx_valid,
  output logic               frame_err,
  output logic               rx_busy
);

  localparam int HALF  = BPS_MAX / 2;
  localparam int BPS_W = $clog2(BPS_MAX);
  localparam int BIT_W = $clog2(BIT_MAX + 1);

  localparam logic [BPS_W-1:0] HALF_END = BPS_W'(HALF - 1);
  localparam logic [BPS_W-1:0] BPS_END  = BPS_W'(BPS_MAX - 1);
  localparam logic [BIT_W-1:0] BIT_END  = BIT_W'(BIT_MAX - 1);

  logic rx_s2;
  logic rx_d_q;
  logic fall;

  uart_state_e        state_q,     state_d;
  logic [BPS_W-1:0]   bps_cnt_q,   bps_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q,   bit_cnt_d;
  logic [BIT_MAX-1:0] shift_q,     shift_d;
  logic [BIT_MAX-1:0] rx_data_q,   rx_data_d;
  logic               rx_valid_q,  rx_valid_d;
  logic               frame_err_q, frame_err_d;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (rx),
    .q_o   (rx_s2)
  );

  assign fall = rx_d_q & ~rx_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_d_q      <= 1'b1;
      state_q     <= IDLE;
      bps_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_d_q      <= rx_s2;
      state_q     <= state_d;
      bps_cnt_q   <= bps_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bps_cnt_d   = bps_cnt_q + 1'b1;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        bps_cnt_d = '0;
        bit_cnt_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        // A line that is high again at half a bit was only a glitch.
        if (bps_cnt_q == HALF_END) begin
          bps_cnt_d = '0;
          state_d   = rx_s2 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bps_cnt_q == BPS_END) begin
          bps_cnt_d = '0;
          shift_d   = {rx_s2, shift_q[BIT_MAX-1:1]};
          if (bit_cnt_q == BIT_END) begin
            bit_cnt_d = '0;
            state_d   = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        // Leave at mid stop bit so an immediately following start edge is seen.
        if (bps_cnt_q == BPS_END) begin
          bps_cnt_d = '0;
          state_d   = IDLE;
          if (rx_s2) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
    endcase
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: a behavioural serial driver feeds frames and
// a queue of expected outcomes is matched against every output pulse.
module tb_uart_rx;

  localparam int BPS  = 16;
  localparam int BITS = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  always #5 clk = ~clk;

  uart_rx #(.BPS_MAX(BPS), .BIT_MAX(BITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Expected outcome per frame: {is_error, data}
  logic [8:0] exp_q[$];
  logic [7:0] last_good = 8'h00;
  int         n_valid = 0, n_err = 0;
  int         exp_valid = 0, exp_err = 0;
  int         cyc = 0;
  int         t_first_valid = -1;
  logic       prev_pulse = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [8:0] e;
    if (rst !== 1'b0) begin
      prev_pulse = 1'b0;
    end else if (rx_valid || frame_err) begin
      chk("exclusive", {31'd0, rx_valid & frame_err}, 0);
      chk("pulse_1cyc", {31'd0, prev_pulse}, 0);
      chk("busy_at_pulse", {31'd0, rx_busy}, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, rx_valid, frame_err}, 0);
      end else begin
        e = exp_q.pop_front();
        if (e[8]) begin
          chk("err_kind", {31'd0, frame_err}, 1);
          chk("err_data_kept", {24'd0, rx_data}, {24'd0, last_good});
          n_err++;
        end else begin
          chk("valid_kind", {31'd0, rx_valid}, 1);
          chk("rx_data", {24'd0, rx_data}, {24'd0, e[7:0]});
          last_good = e[7:0];
          n_valid++;
          if (t_first_valid < 0) t_first_valid = cyc;
        end
      end
      prev_pulse = 1'b1;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BPS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    exp_q.push_back({~stop, d});
    if (stop) exp_valid++; else exp_err++;
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_nvalid"}, n_valid, exp_valid);
    chk({tag, "_nerr"}, n_err, exp_err);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_data"}, {24'd0, rx_data}, 0);
    chk({tag, "_valid"}, {31'd0, rx_valid}, 0);
    chk({tag, "_ferr"}, {31'd0, frame_err}, 0);
    chk({tag, "_busy"}, {31'd0, rx_busy}, 0);
  endtask

  initial begin
    int t0;
    int lat;
    logic [7:0] b;
    logic [7:0] bb[3];
    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b0;
    idle(5);

    // Good frame with latency measurement
    t0 = cyc;
    send_frame(8'h5A, 1'b1);
    wait_drain("t1_drain");
    lat = t_first_valid - t0;
    chk("t1_latency", {31'd0, (lat >= 154 && lat <= 156)}, 1);
    chk("t1_busy_after", {31'd0, rx_busy}, 0);
    chk_counts("t1");
    idle(10);

    // Back-to-back frames, fixed then random
    bb[0] = 8'h00; bb[1] = 8'hFF; bb[2] = 8'hA5;
    for (int i = 0; i < 3; i++) send_frame(bb[i], 1'b1);
    for (int i = 0; i < 20; i++) send_frame(8'($urandom), 1'b1);
    wait_drain("t2_drain");
    chk_counts("t2");
    idle(10);

    // Glitch shorter than half a bit
    rx = 1'b0;
    repeat (5) @(negedge clk);
    chk("t3_busy_in_glitch", {31'd0, rx_busy}, 1);
    idle(20);
    chk("t3_idle", {31'd0, rx_busy}, 0);
    chk_counts("t3");

    // Framing error, then line held low
    send_frame(8'h3C, 1'b0);
    wait_drain("t4_drain");
    rx = 1'b0;
    repeat (60) @(negedge clk);
    chk("t4_no_retrigger", {31'd0, rx_busy}, 0);
    chk_counts("t4");
    idle(20);

    // Reset during data bit 4 of 0x81
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    chk("t5_busy_pre_rst", {31'd0, rx_busy}, 1);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    chk_zero_outputs("t5_in_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_good = 8'h00;
    idle(5);
    send_frame(8'h42, 1'b1);
    wait_drain("t5_drain");
    chk_counts("t5");

    // Loopback of every byte value with random idle gaps
    for (int i = 0; i < 256; i++) begin
      send_frame(8'(i), 1'b1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 20));
    end
    wait_drain("t6_drain");
    chk_counts("t6");

    // Random mix of good and bad stop bits
    for (int i = 0; i < 30; i++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        send_frame(b, 1'b0);
        idle(BPS);
      end else begin
        send_frame(b, 1'b1);
      end
    end
    wait_drain("t7_drain");
    chk_counts("t7");
    chk("final_data", {24'd0, rx_data}, {24'd0, last_good});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART serial receiver. It is the downstream counterpart of the team's UART transmitter and consumes its serial line output. It converts an 8N1 asynchronous frame on `rx` into a parallel byte with a one-cycle valid pulse. Framing errors are flagged and false start bits (glitches) are rejected. It sits between the board RX pin (or the transmitter's `tx` in loopback) and the byte consumer logic.

Parameters:
- BPS_MAX, 5208, clock cycles per bit (50 MHz / 9600 baud); legal range 4..65535.
- BIT_MAX, 8, data bits per frame; legal range 5..8.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- rx  input  1  serial line; idle high; asynchronous to clk.
- rx_data  output  BIT_MAX  last good byte received, LSB = first data bit.
- rx_valid  output  1  one-cycle pulse: rx_data updated with a good frame.
- frame_err  output  1  one-cycle pulse: stop bit sampled low; frame discarded.
- rx_busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE, rx_data=0, rx_valid=0, frame_err=0, rx_busy=0, counters=0, synchronizer flops=1.
  - Reset mid-frame aborts the frame immediately, with no pulse.
  - After release, the block waits for a fresh falling edge.
- Input conditioning: two-flop synchronizer (rx_s1, rx_s2), then one more flop rx_d for edge detection.
  - fall = rx_d & ~rx_s2.
  - Synchronizer latency is 2 cycles; all timing below is relative to rx_s2.
- Constants: HALF = BPS_MAX/2 (integer divide).
  - bps_cnt width = clog2(BPS_MAX).
  - bit_cnt width = clog2(BIT_MAX+1).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: bps_cnt=0, bit_cnt=0. On fall, go to START.
  - START: bps_cnt counts from 0. At bps_cnt==HALF-1, sample rx_s2 and clear bps_cnt:
    - 0 goes to DATA.
    - 1 is a glitch and goes to IDLE, with no pulse.
  - DATA: bps_cnt counts 0..BPS_MAX-1 and wraps. At bps_cnt==BPS_MAX-1 (bit centre):
    - shift register <= {rx_s2, shift[BIT_MAX-1:1]}; bit_cnt++.
    - When bit_cnt reaches BIT_MAX-1 at that sample, clear bit_cnt and go to STOP.
  - STOP: at bps_cnt==BPS_MAX-1, sample rx_s2, then go to IDLE in the same cycle:
    - 1: rx_data <= shift, and rx_valid=1 for exactly the next cycle.
    - 0: frame_err=1 for exactly the next cycle; rx_data is unchanged.
- Stop-bit timing: the return to IDLE happens at mid stop bit, so a start bit immediately after the stop bit is caught (back-to-back frames at full rate).
- Line held low after a framing error: there is no new falling edge, so the block stays in IDLE until the line returns high and falls again. It never re-triggers on a constant low.
- Edges while busy: falling edges while state != IDLE are ignored.
- Outputs are registered; rx_valid and frame_err are never high together.
- rx_busy is combinational from state (registered state, no glitch).
- Latency: rx_valid rises 3 + HALF + BIT_MAX·BPS_MAX + BPS_MAX cycles after the rx pin falling edge (±1 for edge alignment).

Decomposition:
- Shared package (uart_pkg):
  - state encoding localparams IDLE/START/DATA/STOP, shared with the transmitter.
  - default BPS_MAX/BIT_MAX.
  - baud constant helper (CLK_HZ / BAUD).
- One natural sub-module: sync_2ff, a generic two-flop synchronizer with reset value parameter. It is reusable for other async inputs.
- The rest is kept flat.

Test Plan:
All scenarios use BPS_MAX=16, BIT_MAX=8 in simulation.
1. Good frame: drive 0x5A LSB-first, 16 cycles/bit -> one rx_valid pulse with rx_data=0x5A; frame_err stays 0; rx_busy falls at mid stop bit.
2. Back-to-back: frames 0x00, 0xFF, 0xA5 with no idle gap between stop and start bits -> three rx_valid pulses in order with values 0x00, 0xFF, 0xA5.
3. Glitch: rx low for 5 cycles (< HALF=8), then high -> no rx_valid, no frame_err, state back to IDLE after about 8 cycles.
4. Framing error: send 0x3C with stop bit low -> frame_err pulse of 1 cycle, rx_valid=0, rx_data keeps its previous value; holding rx low afterwards produces no further pulses.
5. Reset mid-frame: assert rst during data bit 4 of 0x81, release, then send 0x42 -> no pulse for 0x81; rx_data=0x42 with exactly one rx_valid; all outputs 0 while rst=1.
6. Loopback: connect the team transmitter's tx to rx and send 0x00..0xFF -> 256 rx_valid pulses, each rx_data equal to the transmitted byte.
